logic_op_unit: RTL and testbench
================================

Name: logic_op_unit

Overview:
- Parametrised, clocked successor to the two-input single-bit AND cell.
- Applies a selectable bitwise operation (AND, OR, XOR, ANDN) to two WIDTH-bit operands per accepted beat.
- Optionally folds results across a multi-beat burst (accumulate mode).
- Buffers results in an output FIFO behind valid/ready handshakes.
- Sits between a producer of operand pairs and a result consumer in datapath test structures.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  unit can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
- in_acc  input  1  beat belongs to an accumulate burst.
- in_last  input  1  final beat of an accumulate burst (ignored when in_acc=0).
- out_valid  output  1  result available at FIFO head.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  FIFO head result.
- out_count  output  $clog2(DEPTH+1)  FIFO occupancy.
- busy  output  1  accumulate burst open.

Behaviour:
- Reset (async assert, sync deassert):
  - FIFO empty; out_valid=0, out_data=0, out_count=0.
  - busy=0; accumulator=0; latched op=AND.
  - in_ready=1 from the first edge after deassertion.
- Accept condition: in_valid & in_ready. Pop condition: out_valid & out_ready.
- in_ready = (out_count != DEPTH). It is not pop-aware: when full, a beat offered while a pop occurs is not accepted that cycle.
- Per-beat result: r = in_a OP in_b, bitwise, WIDTH bits, no carries.
- Single beat (in_acc=0):
  - r is pushed at the accepting edge.
  - out_valid rises the following cycle (latency 1 if FIFO was empty).
  - Allowed while busy; the accumulator and latched op are untouched.
- Accumulator FSM states:
  - IDLE:
    - Accepted in_acc=1, in_last=0: latch in_op, accumulator := r, go BUSY, no push.
    - Accepted in_acc=1, in_last=1: push r, stay IDLE.
  - BUSY:
    - Accepted in_acc=1 uses the LATCHED op for r; in_op is ignored mid-burst.
    - in_last=0: accumulator := fold(accumulator, r), no push.
    - in_last=1: push fold(accumulator, r), accumulator := 0, go IDLE.
- Fold function: AND for AND/ANDN, OR for OR, XOR for XOR.
- busy = (state == BUSY), registered.
- Non-pushing accumulate beats also require in_ready=1, for one uniform accept rule.
- FIFO:
  - Circular, read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop leave out_count unchanged.
  - Pop on empty is impossible (out_valid=0).
  - out_data holds its value when empty.
- out_valid and out_data are stable while out_valid=1 and out_ready=0.
- Reset mid-burst or with a non-empty FIFO discards everything; no partial result is emitted.

Decomposition:
- Package logic_op_pkg:
  - op_e enum (OP_AND, OP_OR, OP_XOR, OP_ANDN).
  - acc_state_e (ACC_IDLE, ACC_BUSY).
  - function apply_op(op, a, b).
  - function fold_op(op, x, y).
- Sub-module logic_op_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push/pop/full/empty/count/head.
  - Instantiated once for the output buffer.

Test Plan (WIDTH=8, DEPTH=4):
- Single ops: beats (A5,0F,AND), (A5,0F,OR), (A5,0F,XOR), (A5,0F,ANDN), out_ready=1 -> out_data 05, AF, AA, A0 in order, each one cycle after acceptance.
- Accumulate XOR burst: (01,00), (02,00), (04,00,last), op XOR -> one result 07. busy=1 during beats 2-3, 0 after the last beat. No output for beats 1-2.
- Mid-burst op change: burst started with AND on (FF,F0), next beat in_op=OR on (3C,00) last -> r uses AND (00), fold AND -> output 00.
- Backpressure: out_ready=0, push 5 single beats -> out_count reaches 4, in_ready=0, 5th beat held. Then out_ready=1 for 1 cycle -> 5th beat accepted next cycle. Order is preserved.
- Interleave: single beat (0F,F0,OR) while busy in an XOR burst -> FF emitted immediately; burst result unaffected.
- Reset: rst_n low mid-burst with 3 FIFO entries -> out_valid=0, out_count=0, busy=0 asynchronously. A post-reset single beat behaves normally.

Source files
------------

// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - shared types and bitwise helpers for the logic op unit
//    op_e        : operation select (AND, OR, XOR, ANDN)
//    acc_state_e : accumulate FSM states
//    apply_op    : one result bit of a OP b
//    fold_op     : one bit of the burst fold of x with y
package logic_op_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_ANDN = 2'b11
   } op_e;

   typedef enum logic {
      ACC_IDLE = 1'b0,
      ACC_BUSY = 1'b1
   } acc_state_e;

   function automatic logic apply_op(input op_e op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_ANDN: r = a & ~b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // ANDN folds with AND: a burst of masked terms keeps only bits set in every term.
   function automatic logic fold_op(input op_e op, input logic x, input logic y);
      logic r;
      case (op)
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         default: r = x & y;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_op_fifo.sv
// rtl/logic_op_fifo.sv - circular result buffer with occupancy count
//    push/push_data : write one entry (ignored when full)
//    pop            : drop head entry (ignored when empty)
//    full/empty     : occupancy flags
//    count          : number of stored entries
//    head           : oldest entry, or last popped value while empty
module logic_op_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [WIDTH-1:0]           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      hold_d   = hold_q;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         hold_d   = mem_q[rd_ptr_q];
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
      end
   end

   // Storage needs no reset: it is only visible through head when non-empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   // Keep the last delivered value on the output once drained.
   assign count = count_q;
   assign head  = empty ? hold_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - selectable bitwise op with burst accumulate and output FIFO
//    in_valid/in_ready       : operand beat handshake
//    in_a/in_b/in_op         : operands and operation
//    in_acc/in_last          : accumulate burst membership and end marker
//    out_valid/out_ready     : result handshake
//    out_data/out_count      : FIFO head and occupancy
//    busy                    : accumulate burst open
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic [1:0]                 in_op,
   input  logic                       in_acc,
   input  logic                       in_last,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] out_count,
   output logic                       busy
);

   acc_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   op_e              op_q, op_d;

   op_e              op_use;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] folded;
   logic             accept;
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             fifo_full, fifo_empty;

   assign accept = in_valid & in_ready;

   // Mid-burst beats reuse the op captured on the opening beat.
   assign op_use = (state_q == ACC_BUSY && in_acc) ? op_q : op_e'(in_op);

   always_comb begin
      r      = '0;
      folded = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i]      = apply_op(op_use, in_a[i], in_b[i]);
         folded[i] = fold_op(op_q, acc_q[i], r[i]);
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      op_d      = op_q;
      push      = 1'b0;
      push_data = r;
      if (accept) begin
         if (!in_acc) begin
            push = 1'b1;
         end else begin
            case (state_q)
               ACC_IDLE: begin
                  if (in_last) begin
                     push = 1'b1;
                  end else begin
                     op_d    = op_e'(in_op);
                     acc_d   = r;
                     state_d = ACC_BUSY;
                  end
               end
               ACC_BUSY: begin
                  if (in_last) begin
                     push      = 1'b1;
                     push_data = folded;
                     acc_d     = '0;
                     state_d   = ACC_IDLE;
                  end else begin
                     acc_d = folded;
                  end
               end
               default: state_d = ACC_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC_IDLE;
         acc_q   <= '0;
         op_q    <= OP_AND;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
      end
   end

   logic_op_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (out_valid & out_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (out_count),
      .head      (out_data)
   );

   // Not pop-aware: a full FIFO refuses a beat even while its head is leaving.
   assign in_ready  = ~fifo_full;
   assign out_valid = ~fifo_empty;
   assign busy      = (state_q == ACC_BUSY);

endmodule

// File: tb/tb_logic_op_unit.sv
// tb/tb_logic_op_unit.sv - directed table and sequence checks for logic_op_unit
module tb_logic_op_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [1:0] in_op;
   logic       in_acc;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_count;
   logic       busy;

   int tests;
   int failed;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [8];
   logic [7:0] drain_exp [4];

   logic_op_unit #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic acc, input logic last);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_acc   = acc;
      in_last  = last;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a     = 8'h00;
      in_b     = 8'h00;
      in_op    = 2'b00;
      in_acc   = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      tests  = 0;
      failed = 0;

      vecs[0] = '{a: 8'hA5, b: 8'h0F, op: 2'b00, exp: 8'h05};
      vecs[1] = '{a: 8'hA5, b: 8'h0F, op: 2'b01, exp: 8'hAF};
      vecs[2] = '{a: 8'hA5, b: 8'h0F, op: 2'b10, exp: 8'hAA};
      vecs[3] = '{a: 8'hA5, b: 8'h0F, op: 2'b11, exp: 8'hA0};
      vecs[4] = '{a: 8'hFF, b: 8'h00, op: 2'b00, exp: 8'h00};
      vecs[5] = '{a: 8'hFF, b: 8'h00, op: 2'b11, exp: 8'hFF};
      vecs[6] = '{a: 8'h3C, b: 8'hC3, op: 2'b10, exp: 8'hFF};
      vecs[7] = '{a: 8'h00, b: 8'h00, op: 2'b01, exp: 8'h00};
      drain_exp[0] = 8'h22;
      drain_exp[1] = 8'h33;
      drain_exp[2] = 8'h44;
      drain_exp[3] = 8'h55;

      rst_n     = 1'b0;
      out_ready = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_out_count", 32'(out_count), 32'h0);
      check("reset_busy",      32'(busy),      32'h0);
      check("reset_out_data",  32'(out_data),  32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_in_ready", 32'(in_ready), 32'h1);

      // Single-beat table, consumer always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         offer(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0);
         @(negedge clk);
         idle();
         check($sformatf("single%0d_valid", i), 32'(out_valid), 32'h1);
         check($sformatf("single%0d_data", i),  32'(out_data),  32'(vecs[i].exp));
         @(negedge clk);
         check($sformatf("single%0d_drained", i), 32'(out_count), 32'h0);
      end

      // XOR accumulate burst 01^02^04.
      offer(8'h01, 8'h00, 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      check("xor_b1_busy",  32'(busy),      32'h1);
      check("xor_b1_noout", 32'(out_valid), 32'h0);
      offer(8'h02, 8'h00, 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      check("xor_b2_busy",  32'(busy),      32'h1);
      check("xor_b2_noout", 32'(out_valid), 32'h0);
      offer(8'h04, 8'h00, 2'b10, 1'b1, 1'b1);
      @(negedge clk);
      idle();
      check("xor_end_busy",  32'(busy),      32'h0);
      check("xor_end_valid", 32'(out_valid), 32'h1);
      check("xor_end_data",  32'(out_data),  32'h07);
      @(negedge clk);

      // Op change mid-burst is ignored: AND(3C,00)=00, fold AND F0&00=00.
      offer(8'hFF, 8'hF0, 2'b00, 1'b1, 1'b0);
      @(negedge clk);
      offer(8'h3C, 8'h00, 2'b01, 1'b1, 1'b1);
      @(negedge clk);
      idle();
      check("opchg_valid", 32'(out_valid), 32'h1);
      check("opchg_data",  32'(out_data),  32'h00);
      check("opchg_busy",  32'(busy),      32'h0);
      @(negedge clk);

      // Backpressure: fill, hold the fifth beat, release one slot.
      out_ready = 1'b0;
      offer(8'h11, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      offer(8'h22, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      offer(8'h33, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      offer(8'h44, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_full_count", 32'(out_count), 32'h4);
      check("bp_full_ready", 32'(in_ready),  32'h0);
      offer(8'h55, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_held_count", 32'(out_count), 32'h4);
      check("bp_head_stable", 32'(out_data), 32'h11);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_pop_no_accept", 32'(out_count), 32'h3);
      @(negedge clk);
      idle();
      check("bp_fifth_accepted", 32'(out_count), 32'h4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_order%0d", i), 32'(out_data), 32'(drain_exp[i]));
         @(negedge clk);
      end
      check("bp_empty_count", 32'(out_count), 32'h0);
      check("bp_empty_valid", 32'(out_valid), 32'h0);
      check("bp_empty_hold",  32'(out_data),  32'h55);

      // Single beat interleaved into an XOR burst (latched op reused on the last beat).
      offer(8'h10, 8'h00, 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      check("il_busy", 32'(busy), 32'h1);
      offer(8'h0F, 8'hF0, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      check("il_single_valid", 32'(out_valid), 32'h1);
      check("il_single_data",  32'(out_data),  32'hFF);
      check("il_still_busy",   32'(busy),      32'h1);
      offer(8'h20, 8'h00, 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      idle();
      check("il_burst_count", 32'(out_count), 32'h1);
      check("il_burst_data",  32'(out_data),  32'h30);
      check("il_burst_busy",  32'(busy),      32'h0);
      @(negedge clk);

      // Asynchronous reset with three queued results and an open burst.
      out_ready = 1'b0;
      offer(8'h01, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      offer(8'h02, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      offer(8'h03, 8'h00, 2'b01, 1'b0, 1'b0);
      @(negedge clk);
      offer(8'h10, 8'h00, 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      idle();
      check("pre_rst_count", 32'(out_count), 32'h3);
      check("pre_rst_busy",  32'(busy),      32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'h0);
      check("async_rst_count", 32'(out_count), 32'h0);
      check("async_rst_busy",  32'(busy),      32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;
      offer(8'hA5, 8'h0F, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      idle();
      check("post_rst_valid", 32'(out_valid), 32'h1);
      check("post_rst_data",  32'(out_data),  32'h05);
      check("post_rst_count", 32'(out_count), 32'h1);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
